ahb_slave_if: RTL and testbench

AHB-side front end of the AHB-to-APB bridge, placed directly upstream of the bridge FSM. It qualifies AHB transfers into a single-cycle Valid strobe and decodes the APB slave select (Tempselx). It pipelines address, write data and the write flag two deep (Haddr1/Haddr2, HWdata1/HWdata2, Hwritereg) for the FSM's pending-write path. It also generates the two-cycle AHB ERROR response for out-of-window addresses and passes PRdata back to the AHB master.

---
 rtl/ahb_slave_if_pkg.sv | 28 ++
 rtl/ahb_addr_decode.sv | 33 +++
 rtl/ahb_slave_if.sv | 158 +++++++++++++++
 tb/tb_ahb_slave_if.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_slave_if_pkg.sv
// Shared AHB-to-APB bridge definitions: transfer/response encodings, error FSM states,
// and the APB slave-select constants.
package ahb_slave_if_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ERR_OKAY = 2'b00,
        ERR_ERR1 = 2'b01,
        ERR_ERR2 = 2'b10
    } err_state_e;

    localparam int NUM_SLV = 3;

    localparam logic [NUM_SLV-1:0] SEL_NONE = 3'b000;
    localparam logic [NUM_SLV-1:0] SEL_SLV0 = 3'b001;
    localparam logic [NUM_SLV-1:0] SEL_SLV1 = 3'b010;
    localparam logic [NUM_SLV-1:0] SEL_SLV2 = 3'b100;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational bridge window decode: in-range flag and one-hot APB slave select.
// Slaves occupy contiguous 2^SLV_SPAN_LOG2-byte regions starting at BASE_ADDR.
module ahb_addr_decode
    import ahb_slave_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          SLV_SPAN_LOG2 = 26
) (
    input  logic [31:0]        haddr_i,
    output logic               in_range_o,
    output logic [NUM_SLV-1:0] sel_o
);

    logic [31:0] offset;
    logic [31:0] idx;

    always_comb begin
        offset     = haddr_i - BASE_ADDR;
        idx        = offset >> SLV_SPAN_LOG2;
        // Below-base addresses wrap to a huge offset, but idx alone is not a safe guard
        in_range_o = (haddr_i >= BASE_ADDR) && (idx < 32'(NUM_SLV));
        sel_o      = SEL_NONE;
        if (in_range_o) begin
            case (idx)
                32'd0:   sel_o = SEL_SLV0;
                32'd1:   sel_o = SEL_SLV1;
                32'd2:   sel_o = SEL_SLV2;
                default: sel_o = SEL_NONE;
            endcase
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: transfer qualification, slave decode, 2-deep
// address/data pipeline and two-cycle ERROR response. Optional AHB_XFER_CNT_EN adds counters.
module ahb_slave_if
    import ahb_slave_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          SLV_SPAN_LOG2 = 26
) (
    input  logic               Hclk,
    input  logic               Hreset,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [1:0]         Htrans,
    input  logic [31:0]        Haddr,
    input  logic [31:0]        HWdata,
    input  logic [31:0]        PRdata,
    output logic               Valid,
    output logic [31:0]        Haddr1,
    output logic [31:0]        Haddr2,
    output logic [31:0]        HWdata1,
    output logic [31:0]        HWdata2,
    output logic               Hwritereg,
    output logic [NUM_SLV-1:0] Tempselx,
    output logic [31:0]        Hrdata,
    output logic               Hresp,
    output logic               Err_hready
`ifdef AHB_XFER_CNT_EN
    ,
    output logic [15:0]        Wr_cnt,
    output logic [15:0]        Rd_cnt
`endif
);

    logic        active;
    logic        in_range;
    err_state_e  err_state_q;
    logic        hresp_q;
    logic        err_hready_q;

    logic [31:0] haddr1_q, haddr1_d;
    logic [31:0] haddr2_q, haddr2_d;
    logic [31:0] hwdata1_q, hwdata1_d;
    logic [31:0] hwdata2_q, hwdata2_d;
    logic        hwrite_q, hwrite_d;

    ahb_addr_decode #(
        .BASE_ADDR     (BASE_ADDR),
        .SLV_SPAN_LOG2 (SLV_SPAN_LOG2)
    ) u_decode (
        .haddr_i    (Haddr),
        .in_range_o (in_range),
        .sel_o      (Tempselx)
    );

    assign active = Hreadyin &&
                    ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));
    // The cancelling address phase seen during ERR1/ERR2 must never be forwarded
    assign Valid  = active && in_range && (err_state_q == ERR_OKAY);
    assign Hrdata = PRdata;

    always_comb begin
        haddr1_d  = haddr1_q;
        haddr2_d  = haddr2_q;
        hwdata1_d = hwdata1_q;
        hwdata2_d = hwdata2_q;
        hwrite_d  = hwrite_q;
        if (Hreadyin) begin
            haddr1_d  = Haddr;
            haddr2_d  = haddr1_q;
            hwdata1_d = HWdata;
            hwdata2_d = hwdata1_q;
            hwrite_d  = Hwrite;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite_q  <= 1'b0;
        end else begin
            haddr1_q  <= haddr1_d;
            haddr2_q  <= haddr2_d;
            hwdata1_q <= hwdata1_d;
            hwdata2_q <= hwdata2_d;
            hwrite_q  <= hwrite_d;
        end
    end

    // Error FSM with registered Hresp/Err_hready: ERR1 stalls, ERR2 completes the response
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            err_state_q  <= ERR_OKAY;
            hresp_q      <= HRESP_OKAY;
            err_hready_q <= 1'b1;
        end else begin
            case (err_state_q)
                ERR_OKAY: begin
                    if (active && !in_range) begin
                        err_state_q  <= ERR_ERR1;
                        hresp_q      <= HRESP_ERROR;
                        err_hready_q <= 1'b0;
                    end
                end
                ERR_ERR1: begin
                    err_state_q  <= ERR_ERR2;
                    hresp_q      <= HRESP_ERROR;
                    err_hready_q <= 1'b1;
                end
                default: begin
                    err_state_q  <= ERR_OKAY;
                    hresp_q      <= HRESP_OKAY;
                    err_hready_q <= 1'b1;
                end
            endcase
        end
    end

    assign Haddr1     = haddr1_q;
    assign Haddr2     = haddr2_q;
    assign HWdata1    = hwdata1_q;
    assign HWdata2    = hwdata2_q;
    assign Hwritereg  = hwrite_q;
    assign Hresp      = hresp_q;
    assign Err_hready = err_hready_q;

`ifdef AHB_XFER_CNT_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (Valid && Hwrite && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (Valid && !Hwrite && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign Wr_cnt = wr_cnt_q;
    assign Rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if; counter checks compile only with AHB_XFER_CNT_EN.
module tb_ahb_slave_if;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] HWdata;
    logic [31:0] PRdata;
    logic        Valid;
    logic [31:0] Haddr1, Haddr2, HWdata1, HWdata2;
    logic        Hwritereg;
    logic [2:0]  Tempselx;
    logic [31:0] Hrdata;
    logic        Hresp;
    logic        Err_hready;
`ifdef AHB_XFER_CNT_EN
    logic [15:0] Wr_cnt, Rd_cnt;
`endif

    int errors = 0;
    int checks = 0;

    ahb_slave_if dut (
        .Hclk       (Hclk),
        .Hreset     (Hreset),
        .Hwrite     (Hwrite),
        .Hreadyin   (Hreadyin),
        .Htrans     (Htrans),
        .Haddr      (Haddr),
        .HWdata     (HWdata),
        .PRdata     (PRdata),
        .Valid      (Valid),
        .Haddr1     (Haddr1),
        .Haddr2     (Haddr2),
        .HWdata1    (HWdata1),
        .HWdata2    (HWdata2),
        .Hwritereg  (Hwritereg),
        .Tempselx   (Tempselx),
        .Hrdata     (Hrdata),
        .Hresp      (Hresp),
        .Err_hready (Err_hready)
`ifdef AHB_XFER_CNT_EN
        ,
        .Wr_cnt     (Wr_cnt),
        .Rd_cnt     (Rd_cnt)
`endif
    );

    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle_bus();
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        Htrans   = 2'b00;
        Haddr    = 32'h0;
        HWdata   = 32'h0;
    endtask

    task automatic test_reset();
        Hreset   = 1'b1;
        Hwrite   = 1'b1;
        Hreadyin = 1'b1;
        Htrans   = 2'b10;
        Haddr    = $urandom;
        HWdata   = $urandom;
        PRdata   = $urandom;
        tick();
        Haddr  = $urandom;
        HWdata = $urandom;
        tick();
        checks++;
        if ({Haddr1, Haddr2, HWdata1, HWdata2} !== 128'h0 || Hwritereg !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: Haddr1=%h Haddr2=%h HWdata1=%h HWdata2=%h Hwritereg=%b, want all 0",
                     Haddr1, Haddr2, HWdata1, HWdata2, Hwritereg);
        end
        checks++;
        if (Hresp !== 1'b0 || Err_hready !== 1'b1) begin
            errors++;
            $display("FAIL reset_resp: Hresp=%b Err_hready=%b, want 0 1", Hresp, Err_hready);
        end
        Hreset = 1'b0;
        idle_bus();
    endtask

    task automatic test_decode();
        logic [31:0] addrs [5] = '{32'h8000_0010, 32'h8400_0000, 32'h8BFF_FFFC,
                                   32'h8C00_0000, 32'h7FFF_FFFF};
        logic [2:0]  sels  [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        // Active NONSEQ for in-range entries only; boundaries checked with IDLE to avoid ERROR
        for (int i = 0; i < 5; i++) begin
            Hreadyin = 1'b1;
            Htrans   = (i < 3) ? 2'b10 : 2'b00;
            Haddr    = addrs[i];
            #1;
            checks++;
            if (Tempselx !== sels[i] || Valid !== (i < 3)) begin
                errors++;
                $display("FAIL decode[%0d]: addr=%h Tempselx=%b Valid=%b, want %b %b",
                         i, addrs[i], Tempselx, Valid, sels[i], (i < 3));
            end
            tick();
        end
        Htrans = 2'b01;
        Haddr  = 32'h8400_0000;
        #1;
        checks++;
        if (Valid !== 1'b0 || Tempselx !== 3'b010) begin
            errors++;
            $display("FAIL decode_busy: Valid=%b Tempselx=%b, want 0 010", Valid, Tempselx);
        end
        PRdata = 32'hA5A5_1234;
        #1;
        checks++;
        if (Hrdata !== 32'hA5A5_1234) begin
            errors++;
            $display("FAIL hrdata: got %h want a5a51234", Hrdata);
        end
        tick();
        idle_bus();
    endtask

    task automatic test_write_pipeline();
        Htrans = 2'b10;
        Hwrite = 1'b1;
        Haddr  = 32'h8000_0004;
        tick();
        checks++;
        if (Haddr1 !== 32'h8000_0004 || Hwritereg !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr: Haddr1=%h Hwritereg=%b, want 80000004 1", Haddr1, Hwritereg);
        end
        Htrans = 2'b00;
        Hwrite = 1'b0;
        Haddr  = 32'h0;
        HWdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (HWdata1 !== 32'hDEAD_BEEF || Haddr2 !== 32'h8000_0004) begin
            errors++;
            $display("FAIL wr_data1: HWdata1=%h Haddr2=%h, want deadbeef 80000004", HWdata1, Haddr2);
        end
        HWdata = 32'h0;
        tick();
        checks++;
        if (HWdata2 !== 32'hDEAD_BEEF || HWdata1 !== 32'h0) begin
            errors++;
            $display("FAIL wr_data2: HWdata2=%h HWdata1=%h, want deadbeef 0", HWdata2, HWdata1);
        end
        idle_bus();
    endtask

    task automatic test_stall();
        Htrans = 2'b10;
        Haddr  = 32'h8000_0100;
        HWdata = 32'h1111_2222;
        tick();
        Haddr  = 32'h8000_0200;
        HWdata = 32'h3333_4444;
        tick();
        Hreadyin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // Middle cycle presents an out-of-window address that must not start an error
            Haddr  = (i == 1) ? 32'h9000_0000 : 32'h8000_0300 + 32'(i);
            HWdata = 32'h5555_0000 + 32'(i);
            #1;
            checks++;
            if (Valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_valid[%0d]: Valid=%b want 0", i, Valid);
            end
            tick();
            checks++;
            if (Haddr1 !== 32'h8000_0200 || Haddr2 !== 32'h8000_0100 ||
                HWdata1 !== 32'h3333_4444 || HWdata2 !== 32'h1111_2222 || Hresp !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: Haddr1=%h Haddr2=%h HWdata1=%h HWdata2=%h Hresp=%b",
                         i, Haddr1, Haddr2, HWdata1, HWdata2, Hresp);
            end
        end
        idle_bus();
        tick();
    endtask

    task automatic test_error();
        Htrans = 2'b10;
        Haddr  = 32'h8C00_0000;
        #1;
        checks++;
        if (Valid !== 1'b0 || Tempselx !== 3'b000) begin
            errors++;
            $display("FAIL err_valid: Valid=%b Tempselx=%b, want 0 000", Valid, Tempselx);
        end
        tick();
        checks++;
        if (Hresp !== 1'b1 || Err_hready !== 1'b0) begin
            errors++;
            $display("FAIL err1: Hresp=%b Err_hready=%b, want 1 0", Hresp, Err_hready);
        end
        Haddr = 32'h8000_0040;
        #1;
        checks++;
        if (Valid !== 1'b0) begin
            errors++;
            $display("FAIL err1_valid: Valid=%b want 0", Valid);
        end
        tick();
        checks++;
        if (Hresp !== 1'b1 || Err_hready !== 1'b1 || Valid !== 1'b0) begin
            errors++;
            $display("FAIL err2: Hresp=%b Err_hready=%b Valid=%b, want 1 1 0", Hresp, Err_hready, Valid);
        end
        Htrans = 2'b00;
        tick();
        checks++;
        if (Hresp !== 1'b0 || Err_hready !== 1'b1) begin
            errors++;
            $display("FAIL err_done: Hresp=%b Err_hready=%b, want 0 1", Hresp, Err_hready);
        end
        Htrans = 2'b10;
        Haddr  = 32'h7FFF_FFFC;
        tick();
        checks++;
        if (Hresp !== 1'b1 || Err_hready !== 1'b0) begin
            errors++;
            $display("FAIL err_low: Hresp=%b Err_hready=%b, want 1 0", Hresp, Err_hready);
        end
        Hreset = 1'b1;
        Htrans = 2'b00;
        tick();
        checks++;
        if (Hresp !== 1'b0 || Err_hready !== 1'b1) begin
            errors++;
            $display("FAIL err_reset: Hresp=%b Err_hready=%b, want 0 1", Hresp, Err_hready);
        end
        Hreset = 1'b0;
        tick();
        checks++;
        if (Hresp !== 1'b0) begin
            errors++;
            $display("FAIL err_reset_stay: Hresp=%b want 0", Hresp);
        end
        idle_bus();
    endtask

`ifdef AHB_XFER_CNT_EN
    task automatic test_counters();
        Hreset = 1'b1;
        tick();
        Hreset = 1'b0;
        checks++;
        if (Wr_cnt !== 16'd0 || Rd_cnt !== 16'd0) begin
            errors++;
            $display("FAIL cnt_reset: Wr_cnt=%0d Rd_cnt=%0d, want 0 0", Wr_cnt, Rd_cnt);
        end
        Htrans = 2'b10;
        Haddr  = 32'h8000_0000;
        Hwrite = 1'b1;
        repeat (5) tick();
        Hwrite = 1'b0;
        Htrans = 2'b11;
        repeat (3) tick();
        Hwrite = 1'b1;
        Htrans = 2'b01;
        tick();
        checks++;
        if (Wr_cnt !== 16'd5 || Rd_cnt !== 16'd3) begin
            errors++;
            $display("FAIL cnt_count: Wr_cnt=%0d Rd_cnt=%0d, want 5 3", Wr_cnt, Rd_cnt);
        end
        force dut.wr_cnt_q = 16'hFFFF;
        force dut.rd_cnt_q = 16'hFFFF;
        #1;
        release dut.wr_cnt_q;
        release dut.rd_cnt_q;
        Htrans = 2'b10;
        Hwrite = 1'b1;
        tick();
        Hwrite = 1'b0;
        tick();
        checks++;
        if (Wr_cnt !== 16'hFFFF || Rd_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_sat: Wr_cnt=%h Rd_cnt=%h, want ffff ffff", Wr_cnt, Rd_cnt);
        end
        idle_bus();
    endtask
`endif

    initial begin
        Hreset = 1'b1;
        PRdata = 32'h0;
        idle_bus();
        test_reset();
        test_decode();
        test_write_pipeline();
        test_stall();
        test_error();
`ifdef AHB_XFER_CNT_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
